// File: rtl/tlul_main_mem_arbiter.sv
// Round-robin TL-UL arbiter that hands the single main-memory port to one host per ownership window.
// A window ends on burst limit or idle owner; outstanding responses drain before the next grant.
`timescale 1ns/1ps

package tlul_mm_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_main_mem_arbiter
    import tlul_mm_pkg::*;
#(
    parameter int NumHosts       = 3,
    parameter int MaxOutstanding = 4,
    parameter int MaxBurst       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  tl_h2d_t [NumHosts-1:0]       tl_h_i,
    output tl_d2h_t [NumHosts-1:0]       tl_h_o,
    output tl_h2d_t                      tl_d_o,
    input  tl_d2h_t                      tl_d_i,
    output logic    [NumHosts-1:0]       grant_o,
    output logic                         busy_o,
    output logic                         err_o
);
    localparam int IdxW = $clog2(NumHosts);
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam int BurW = $clog2(MaxBurst + 1);

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_e;

    state_e          state, state_nxt;
    logic [IdxW-1:0] owner, owner_nxt, rr_ptr, rr_nxt, pick, cand;
    logic [OutW-1:0] outstanding, out_nxt;
    logic [BurW-1:0] burst, burst_nxt;
    logic            pick_ok;
    logic            routed, has_out, a_open, a_beat, d_beat;
    tl_h2d_t         own_req;

    assign own_req = tl_h_i[owner];
    assign routed  = (state != IDLE);
    assign has_out = (outstanding != '0);
    assign a_open  = (state == OWNED) && (outstanding != OutW'(MaxOutstanding));
    assign a_beat  = a_open && own_req.a_valid && tl_d_i.a_ready;
    assign d_beat  = routed && has_out && tl_d_i.d_valid && own_req.d_ready;
    assign busy_o  = routed;
    // A response with nobody waiting for it is swallowed and flagged.
    assign err_o   = !rst_i && tl_d_i.d_valid && !(routed && has_out);

    always_comb begin
        tl_d_o         = own_req;
        tl_d_o.a_valid = a_open && own_req.a_valid;
        tl_d_o.d_ready = (routed && has_out) ? own_req.d_ready : 1'b1;
    end

    always_comb begin
        for (int h = 0; h < NumHosts; h++) begin
            grant_o[h]         = routed && (owner == IdxW'(h));
            tl_h_o[h]          = tl_d_i;
            tl_h_o[h].d_valid  = grant_o[h] && has_out && tl_d_i.d_valid;
            tl_h_o[h].a_ready  = grant_o[h] && a_open && tl_d_i.a_ready;
        end
    end

    always_comb begin
        pick_ok = 1'b0;
        pick    = owner;
        cand    = '0;
        // Search starts just past the last owner so every host gets a turn.
        for (int k = 1; k <= NumHosts; k++) begin
            cand = IdxW'((int'(rr_ptr) + k) % NumHosts);
            if (!pick_ok && tl_h_i[cand].a_valid) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        burst_nxt = burst;
        out_nxt   = outstanding + OutW'(a_beat) - OutW'(d_beat);
        unique case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nxt = OWNED;
                    owner_nxt = pick;
                    burst_nxt = '0;
                end
            end
            OWNED: begin
                burst_nxt = burst + BurW'(a_beat);
                if (burst_nxt == BurW'(MaxBurst) || !own_req.a_valid) begin
                    state_nxt = (out_nxt != '0) ? DRAIN : IDLE;
                    rr_nxt    = owner;
                end
            end
            DRAIN: begin
                if (out_nxt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= IdxW'(NumHosts - 1);
            outstanding <= '0;
            burst       <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_nxt;
            outstanding <= out_nxt;
            burst       <= burst_nxt;
        end
    end
endmodule

// File: tb/tb_tlul_main_mem_arbiter.sv
// Scoreboard bench: host queues feed requests, a latency-model memory answers, responses are
// checked per host against data derived from the request address.
`timescale 1ns/1ps

module tb_tlul_main_mem_arbiter;
    import tlul_mm_pkg::*;

    localparam int NH = 3;
    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  src;
        int          due;
    } mresp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tl_h2d_t [NH-1:0] tl_h_i = '0;
    tl_d2h_t [NH-1:0] tl_h_o;
    tl_h2d_t          tl_d_o;
    tl_d2h_t          tl_d_i = '0;
    logic [NH-1:0]    grant;
    logic             busy, err;

    tlul_main_mem_arbiter #(.NumHosts(NH), .MaxOutstanding(2), .MaxBurst(4)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h_i(tl_h_i), .tl_h_o(tl_h_o),
        .tl_d_o(tl_d_o), .tl_d_i(tl_d_i), .grant_o(grant), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [31:0] hq [NH][$];
    logic [31:0] sb [NH][$];
    mresp_t      mq [$];
    int gseq [$];
    int dcnt [NH], mcnt [NH], stall [NH];
    int errcnt = 0, cyc_n = 0, mem_lat = 2, addr_ctr = 0;
    bit mem_a_ready = 1'b1, mem_d_en = 1'b1, stray = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor at negedge, drive 2 time units after posedge (tests act at +1).
    always begin : env
        bit a_hs [NH];
        bit d_hs [NH];
        bit m_d_hs, d_from_mem;
        logic [NH-1:0] last_g;
        mresp_t m;
        last_g = '0;
        d_from_mem = 1'b0;
        forever begin
            @(negedge clk);
            m_d_hs = tl_d_i.d_valid && tl_d_o.d_ready && d_from_mem;
            if (tl_d_o.a_valid && tl_d_i.a_ready) begin
                m.data = tl_d_o.a_address ^ KEY;
                m.src  = tl_d_o.a_source;
                m.due  = cyc_n + mem_lat;
                mq.push_back(m);
                if (int'(tl_d_o.a_source) < NH) mcnt[int'(tl_d_o.a_source)]++;
            end
            for (int h = 0; h < NH; h++) begin
                a_hs[h] = tl_h_i[h].a_valid && tl_h_o[h].a_ready;
                if (a_hs[h] && hq[h].size() > 0) sb[h].push_back(hq[h][0] ^ KEY);
                d_hs[h] = tl_h_o[h].d_valid && tl_h_i[h].d_ready;
                if (d_hs[h]) begin
                    dcnt[h]++;
                    if (sb[h].size() == 0) chk($sformatf("unexpected_d_h%0d", h), 64'(tl_h_o[h].d_data), 64'hFFFF_FFFF_FFFF);
                    else chk($sformatf("d_data_h%0d", h), 64'(tl_h_o[h].d_data), 64'(sb[h].pop_front()));
                    chk($sformatf("d_source_h%0d", h), 64'(tl_h_o[h].d_source), 64'(h));
                end
                if (grant[h] && tl_h_i[h].a_valid && !tl_h_o[h].a_ready) stall[h]++;
            end
            if (err) errcnt++;
            if (grant != last_g && grant != '0)
                for (int h = 0; h < NH; h++) if (grant[h]) gseq.push_back(h);
            last_g = grant;

            @(posedge clk); #2;
            cyc_n++;
            if (m_d_hs && mq.size() > 0) void'(mq.pop_front());
            for (int h = 0; h < NH; h++) if (a_hs[h] && hq[h].size() > 0) void'(hq[h].pop_front());
            tl_d_i         = '0;
            tl_d_i.a_ready = mem_a_ready;
            d_from_mem     = 1'b0;
            if (stray) begin
                tl_d_i.d_valid  = 1'b1;
                tl_d_i.d_data   = 32'hDEAD_BEEF;
                tl_d_i.d_source = 8'hEE;
            end else if (mem_d_en && mq.size() > 0 && mq[0].due <= cyc_n) begin
                tl_d_i.d_valid  = 1'b1;
                tl_d_i.d_opcode = 3'd1;
                tl_d_i.d_data   = mq[0].data;
                tl_d_i.d_source = mq[0].src;
                d_from_mem      = 1'b1;
            end
            for (int h = 0; h < NH; h++) begin
                tl_h_i[h]         = '0;
                tl_h_i[h].d_ready = 1'b1;
                if (hq[h].size() > 0) begin
                    tl_h_i[h].a_valid   = 1'b1;
                    tl_h_i[h].a_opcode  = 3'd4;
                    tl_h_i[h].a_size    = 2'd2;
                    tl_h_i[h].a_mask    = 4'hF;
                    tl_h_i[h].a_source  = 8'(h);
                    tl_h_i[h].a_address = hq[h][0];
                end
            end
        end
    end

    task automatic slot();  @(posedge clk); #1; endtask
    task automatic probe(); @(negedge clk); #1; endtask

    task automatic push_req(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            hq[h].push_back((32'(h + 1) << 28) | (32'(addr_ctr) << 2));
            addr_ctr++;
        end
    endtask

    task automatic clear_counts();
        gseq.delete();
        errcnt = 0;
        for (int h = 0; h < NH; h++) begin dcnt[h] = 0; mcnt[h] = 0; stall[h] = 0; end
    endtask

    task automatic clear_env();
        mq.delete();
        for (int h = 0; h < NH; h++) begin hq[h].delete(); sb[h].delete(); end
    endtask

    task automatic wait_grant(input logic [NH-1:0] g, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            probe();
            if (grant === g) ok = 1'b1;
        end
        if (!ok) chk({tag, "_grant_timeout"}, 64'(grant), 64'(g));
    endtask

    task automatic wait_mcnt(input int h, input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            probe();
            if (mcnt[h] == n) ok = 1'b1;
        end
        if (!ok) chk({tag, "_beat_timeout"}, 64'(mcnt[h]), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            probe();
            if (!busy && mq.size() == 0 && hq[0].size() == 0 && hq[1].size() == 0 && hq[2].size() == 0 &&
                sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) ok = 1'b1;
        end
        chk({tag, "_idle"}, 64'(ok), 64'(1));
    endtask

    task automatic chk_gseq(input string tag, input int idx, input int exp);
        if (gseq.size() > idx) chk($sformatf("%s_owner%0d", tag, idx), 64'(gseq[idx]), 64'(exp));
        else chk($sformatf("%s_owner%0d_missing", tag, idx), 64'(gseq.size()), 64'(idx + 1));
    endtask

    task automatic do_reset();
        slot(); rst = 1'b1; clear_env();
        slot(); rst = 1'b0;
    endtask

    initial begin
        clear_counts();
        // Reset state
        repeat (3) slot();
        probe();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_dn_avalid", 64'(tl_d_o.a_valid), 64'(0));
        chk("rst_dn_dready", 64'(tl_d_o.d_ready), 64'(1));
        chk("rst_host_aready", 64'({tl_h_o[2].a_ready, tl_h_o[1].a_ready, tl_h_o[0].a_ready}), 64'(0));
        chk("rst_host_dvalid", 64'({tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}), 64'(0));
        slot(); rst = 1'b0;

        // 1: single host, three Gets
        clear_counts();
        slot(); push_req(0, 3);
        probe(); chk("t1_grant_arb", 64'(grant), 64'(0));
        probe(); chk("t1_grant_own", 64'(grant), 64'(3'b001));
        wait_idle("t1");
        chk("t1_dcnt", 64'(dcnt[0]), 64'(3));
        chk("t1_err", 64'(errcnt), 64'(0));
        chk("t1_windows", 64'(gseq.size()), 64'(1));
        // rr pointer now at host0, so host1 wins a tie with host0
        clear_counts();
        slot(); push_req(0, 1); push_req(1, 1);
        wait_idle("t1b");
        chk_gseq("t1b", 0, 1);
        chk_gseq("t1b", 1, 0);

        // 2: hosts 0 and 2 after reset, host0 re-requests while host2 owns
        do_reset();
        clear_counts();
        slot(); push_req(0, 1); push_req(2, 1);
        wait_grant(3'b100, "t2");
        slot(); push_req(0, 1);
        wait_idle("t2");
        chk("t2_windows", 64'(gseq.size()), 64'(3));
        chk_gseq("t2", 0, 0);
        chk_gseq("t2", 1, 2);
        chk_gseq("t2", 2, 0);

        // 3: burst limit with a waiting host
        clear_counts();
        slot(); push_req(1, 6); push_req(0, 1);
        wait_grant(3'b001, "t3");
        chk("t3_h1_beats", 64'(mcnt[1]), 64'(4));
        chk("t3_h1_drained", 64'(dcnt[1]), 64'(4));
        chk_gseq("t3", 0, 1);
        wait_idle("t3");
        chk_gseq("t3", 2, 1);
        chk("t3_h1_total", 64'(dcnt[1]), 64'(6));

        // 4: outstanding limit with memory withholding responses
        clear_counts();
        mem_d_en = 1'b0;
        slot(); push_req(2, 3);
        wait_mcnt(2, 2, "t4");
        for (int i = 0; i < 3; i++) begin
            probe();
            chk($sformatf("t4_stall%0d", i), 64'({tl_h_i[2].a_valid, tl_h_o[2].a_ready}), 64'(2'b10));
        end
        chk("t4_beats_held", 64'(mcnt[2]), 64'(2));
        slot(); mem_d_en = 1'b1;
        probe();
        chk("t4_d_visible", 64'(tl_h_o[2].d_valid), 64'(1));
        chk("t4_ready_in_d", 64'(tl_h_o[2].a_ready), 64'(0));
        probe();
        chk("t4_ready_next", 64'(tl_h_o[2].a_ready), 64'(1));
        wait_idle("t4");
        chk("t4_dcnt", 64'(dcnt[2]), 64'(3));

        // 5: simultaneous A and D beats keep outstanding steady
        clear_counts();
        mem_lat = 1;
        slot(); push_req(0, 4);
        wait_idle("t5");
        chk("t5_no_stall", 64'(stall[0]), 64'(0));
        chk("t5_one_window", 64'(gseq.size()), 64'(1));
        chk("t5_dcnt", 64'(dcnt[0]), 64'(4));
        chk("t5_err", 64'(errcnt), 64'(0));
        mem_lat = 2;

        // 6: reset mid-window then a stray response
        clear_counts();
        mem_d_en = 1'b0;
        slot(); push_req(0, 3);
        wait_mcnt(0, 2, "t6");
        slot(); rst = 1'b1; clear_env();
        slot(); rst = 1'b0;
        probe();
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        mem_d_en = 1'b1;
        errcnt = 0;
        slot(); stray = 1'b1;
        probe();
        chk("t6_stray_dready", 64'(tl_d_o.d_ready), 64'(1));
        chk("t6_stray_err", 64'(err), 64'(1));
        chk("t6_stray_host_dvalid", 64'({tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}), 64'(0));
        slot(); stray = 1'b0;
        probe();
        chk("t6_err_clear", 64'(err), 64'(0));
        chk("t6_err_pulses", 64'(errcnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
